// File: rtl/cfg_dispatcher_if.sv
// Instruction-stream and core configuration-port bundle of cfg_dispatcher.
// The master modport is the stream source / core side; the slave modport is the dispatcher.
interface cfg_dispatcher_if #(
    parameter int unsigned IWIDTH      = 32,
    parameter int unsigned DATA_CWIDTH = 48,
    parameter int unsigned WICP_CWIDTH = 40,
    parameter int unsigned TMPC_CWIDTH = 32,
    parameter int unsigned POST_CWIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [IWIDTH-1:0]      in_data;
    logic                   in_parity;
    logic                   cfg_valid;
    logic                   cfg_busy;
    logic [DATA_CWIDTH-1:0] cfg_data_data;
    logic [WICP_CWIDTH-1:0] cfg_wicp_data;
    logic [TMPC_CWIDTH-1:0] cfg_tmpc_data;
    logic [POST_CWIDTH-1:0] cfg_post_data;
    logic [15:0]            frame_cnt;
    logic                   err_parity;

    modport master (
        output in_valid, in_data, in_parity, cfg_busy,
        input  in_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
               cfg_post_data, frame_cnt, err_parity
    );

    modport slave (
        input  in_valid, in_data, in_parity, cfg_busy,
        output in_ready, cfg_valid, cfg_data_data, cfg_wicp_data, cfg_tmpc_data,
               cfg_post_data, frame_cnt, err_parity
    );
endinterface

// File: rtl/cfg_dispatcher.sv
// Deserializes instruction words into configuration frames and issues them to the core.
// Define CFG_DISPATCHER_PARITY_EN to check per-beat even parity and drop corrupted frames.
module cfg_dispatcher #(
    parameter int unsigned IWIDTH      = 32,
    parameter int unsigned DATA_CWIDTH = 48,
    parameter int unsigned WICP_CWIDTH = 40,
    parameter int unsigned TMPC_CWIDTH = 32,
    parameter int unsigned POST_CWIDTH = 24
) (
    input logic             clk,
    input logic             rst_n,
    cfg_dispatcher_if.slave cfg_io
);
    localparam int unsigned CWIDTH = DATA_CWIDTH + WICP_CWIDTH + TMPC_CWIDTH + POST_CWIDTH;
    localparam int unsigned BEATS  = (CWIDTH + IWIDTH - 1) / IWIDTH;
    localparam int unsigned BeatW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WicpLo = DATA_CWIDTH;
    localparam int unsigned TmpcLo = WicpLo + WICP_CWIDTH;
    localparam int unsigned PostLo = TmpcLo + TMPC_CWIDTH;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

    state_e                 state_q;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic                   abuf_full_q, abuf_full_d;
    logic                   ibuf_full_q, ibuf_full_d;
    logic                   rdy_q;
    logic                   cfg_valid_q;
    logic [15:0]            frame_cnt_q;
    logic [DATA_CWIDTH-1:0] data_q;
    logic [WICP_CWIDTH-1:0] wicp_q;
    logic [TMPC_CWIDTH-1:0] tmpc_q;
    logic [POST_CWIDTH-1:0] post_q;
    logic [CWIDTH-1:0]      abuf;
    logic                   accept, last_beat, ibuf_free, move, abuf_clr, frame_ok;

    assign cfg_io.in_ready = rdy_q & ~abuf_full_q;
    assign accept          = cfg_io.in_valid & cfg_io.in_ready;
    assign last_beat       = (beat_q == BeatW'(BEATS - 1));
    assign ibuf_free       = (state_q == StWaitDone) & ~cfg_io.cfg_busy;
    // IBUF may be refilled in the very cycle the core releases it.
    assign move            = abuf_full_q & (~ibuf_full_q | ibuf_free);

`ifdef CFG_DISPATCHER_PARITY_EN
    logic drop_q, err_q, beat_bad;

    assign beat_bad = accept & ((^cfg_io.in_data) != cfg_io.in_parity);
    // A bad beat poisons its frame; the remaining beats are still consumed to stay aligned.
    assign frame_ok = ~(drop_q | beat_bad);
    assign abuf_clr = accept & last_beat & ~frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (beat_bad) err_q <= 1'b1;
            if (accept && last_beat) drop_q <= 1'b0;
            else if (beat_bad)       drop_q <= 1'b1;
        end
    end

    assign cfg_io.err_parity = err_q;
`else
    assign frame_ok          = 1'b1;
    assign abuf_clr          = 1'b0;
    assign cfg_io.err_parity = 1'b0;
`endif

    for (genvar k = 0; k < BEATS; k++) begin : g_beat
        localparam int unsigned Lo = k * IWIDTH;
        localparam int unsigned W  = (CWIDTH - Lo < IWIDTH) ? CWIDTH - Lo : IWIDTH;
        logic [W-1:0] part_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                part_q <= '0;
            end else if (abuf_clr) begin
                part_q <= '0;
            end else if (accept && beat_q == BeatW'(k)) begin
                part_q <= cfg_io.in_data[W-1:0];
            end
        end

        assign abuf[Lo +: W] = part_q;
    end

    always_comb begin
        beat_d      = beat_q;
        abuf_full_d = abuf_full_q;
        ibuf_full_d = ibuf_full_q;
        if (ibuf_free) ibuf_full_d = 1'b0;
        if (move) begin
            abuf_full_d = 1'b0;
            ibuf_full_d = 1'b1;
        end
        if (accept) begin
            beat_d = last_beat ? '0 : beat_q + BeatW'(1);
            if (last_beat && frame_ok) abuf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            beat_q      <= '0;
            abuf_full_q <= 1'b0;
            ibuf_full_q <= 1'b0;
            data_q      <= '0;
            wicp_q      <= '0;
            tmpc_q      <= '0;
            post_q      <= '0;
        end else begin
            rdy_q       <= 1'b1;
            beat_q      <= beat_d;
            abuf_full_q <= abuf_full_d;
            ibuf_full_q <= ibuf_full_d;
            if (move) begin
                data_q <= abuf[DATA_CWIDTH-1:0];
                wicp_q <= abuf[WicpLo +: WICP_CWIDTH];
                tmpc_q <= abuf[TmpcLo +: TMPC_CWIDTH];
                post_q <= abuf[PostLo +: POST_CWIDTH];
            end
        end
    end

    // Issue FSM; a frame being moved this cycle counts as ready so cfg_valid lands at T+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cfg_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if ((ibuf_full_q || move) && !cfg_io.cfg_busy) begin
                        state_q     <= StIssue;
                        cfg_valid_q <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                StIssue: begin
                    state_q     <= StWaitAck;
                    cfg_valid_q <= 1'b0;
                end
                StWaitAck: begin
                    if (cfg_io.cfg_busy) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (!cfg_io.cfg_busy) state_q <= StIdle;
                end
                default: begin
                    state_q     <= StIdle;
                    cfg_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_io.cfg_valid     = cfg_valid_q;
    assign cfg_io.frame_cnt     = frame_cnt_q;
    assign cfg_io.cfg_data_data = data_q;
    assign cfg_io.cfg_wicp_data = wicp_q;
    assign cfg_io.cfg_tmpc_data = tmpc_q;
    assign cfg_io.cfg_post_data = post_q;
endmodule

// File: tb/tb_cfg_dispatcher.sv
// Directed self-checking bench for cfg_dispatcher: assembly, issue timing, busy handshake,
// reset and the optional parity check (follows CFG_DISPATCHER_PARITY_EN like the design).
module tb_cfg_dispatcher;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cfg_dispatcher_if bus ();

    cfg_dispatcher dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [143:0] mk_frame(input logic [47:0] d, input logic [39:0] w,
                                              input logic [31:0] t, input logic [23:0] p);
        return {p, t, w, d};
    endfunction

    function automatic logic [143:0] got_frame();
        return {bus.cfg_post_data, bus.cfg_tmpc_data, bus.cfg_wicp_data, bus.cfg_data_data};
    endfunction

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.cfg_busy  = 1'b0;
        rst_n         = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Holds a word on the stream until accepted; returns #1 after the accepting edge.
    task automatic send_beat(input logic [31:0] w, input logic p);
        int n;
        n             = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = w;
        bus.in_parity = p;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready=%b after %0d cycles, required 1",
                     bus.in_ready, n);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [143:0] fr, input bit stall, input int bad);
        logic [159:0] pad;
        logic [31:0]  w;
        int           gap;
        pad = {16'hA5A5, fr};  // junk above the frame must be ignored
        for (int k = 0; k < 5; k++) begin
            w = pad[k*32 +: 32];
            if (stall) begin
                gap = $urandom_range(0, 3);
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
            send_beat(w, (^w) ^ (k == bad));
        end
    endtask

    task automatic core_ack(input int n);
        bus.cfg_busy = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        bus.cfg_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_parity = 1'b0;
        bus.cfg_busy  = 1'b0;
        #12;
        checks++;
        if (bus.cfg_valid !== 1'b0) begin
            errors++; $display("FAIL reset_cfg_valid: got %b want 0", bus.cfg_valid);
        end
        checks++;
        if (got_frame() !== 144'h0) begin
            errors++; $display("FAIL reset_fields: got %h want 0", got_frame());
        end
        checks++;
        if (bus.frame_cnt !== 16'h0 || bus.err_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_err: got cnt=%h err=%b want 0/0", bus.frame_cnt,
                     bus.err_parity);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_first_cycle_ready: got %b want 0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single_frame();
        logic [143:0] fr;
        fr = mk_frame(48'h0123_4567_89AB, 40'h11_2233_4455, 32'hDEAD_BEEF, 24'hABCDEF);
        do_reset();
        send_frame(fr, 1'b0, -1);
        checks++;
        if (bus.cfg_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_t1: got valid=%b ready=%b want 0/0", bus.cfg_valid,
                     bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid_t2: got %b want 1", bus.cfg_valid);
        end
        checks++;
        if (got_frame() !== fr) begin
            errors++; $display("FAIL single_fields: got %h want %h", got_frame(), fr);
        end
        checks++;
        if (bus.frame_cnt !== 16'd1) begin
            errors++; $display("FAIL single_cnt: got %0d want 1", bus.frame_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b0 || got_frame() !== fr) begin
            errors++;
            $display("FAIL single_pulse_hold: got valid=%b fields=%h want 0/%h",
                     bus.cfg_valid, got_frame(), fr);
        end
        core_ack(3);
    endtask

    task automatic test_busy_hold();
        logic [143:0] fa, fb;
        bit           seen;
        fa = mk_frame(48'hFEDC_BA98_7654, 40'h55_6677_8899, 32'h0BAD_F00D, 24'h123456);
        fb = mk_frame(48'h1111_2222_3333, 40'h44_5555_6666, 32'h7777_8888, 24'h99AABB);
        do_reset();
        bus.cfg_busy = 1'b1;
        send_frame(fa, 1'b0, -1);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.cfg_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL busy_no_issue: got valid seen=%b want 0", seen);
        end
        bus.cfg_busy = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== fa) begin
            errors++;
            $display("FAIL busy_release_issue: got valid=%b fields=%h want 1/%h",
                     bus.cfg_valid, got_frame(), fa);
        end
        @(posedge clk); #1;
        core_ack(3);
        send_frame(fb, 1'b0, -1);
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== fb || bus.frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL busy_back_idle: got valid=%b fields=%h cnt=%0d want 1/%h/2",
                     bus.cfg_valid, got_frame(), bus.frame_cnt, fb);
        end
        @(posedge clk); #1;
        core_ack(1);
    endtask

    task automatic test_back_to_back();
        logic [143:0] fa, fb;
        bit           bad;
        fa = mk_frame(48'hAAAA_0000_0001, 40'hA1_A2A3_A4A5, 32'hA6A7_A8A9, 24'hAAABAC);
        fb = mk_frame(48'hBBBB_0000_0002, 40'hB1_B2B3_B4B5, 32'hB6B7_B8B9, 24'hBABBBC);
        do_reset();
        send_frame(fa, 1'b0, -1);
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== fa) begin
            errors++;
            $display("FAIL b2b_a_issue: got valid=%b fields=%h want 1/%h", bus.cfg_valid,
                     got_frame(), fa);
        end
        bus.cfg_busy = 1'b1;
        send_frame(fb, 1'b0, -1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_low: got %b want 0", bus.in_ready);
        end
        bad = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.cfg_valid !== 1'b0 || bus.in_ready !== 1'b0 || got_frame() !== fa) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL b2b_hold_during_run: got disturbance=%b want 0", bad);
        end
        bus.cfg_busy = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_refill: got valid=%b ready=%b want 0/1", bus.cfg_valid,
                     bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== fb || bus.frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL b2b_b_issue: got valid=%b fields=%h cnt=%0d want 1/%h/2",
                     bus.cfg_valid, got_frame(), bus.frame_cnt, fb);
        end
        @(posedge clk); #1;
        core_ack(2);
    endtask

    task automatic test_stalled_stream();
        logic [143:0] fr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fr = mk_frame(48'hC0DE_0000_0000 + 48'(i * 7 + 1), 40'h12_3456_7800 + 40'(i),
                          32'h5A5A_0000 + 32'(i), 24'h00F000 + 24'(i));
            send_frame(fr, 1'b1, -1);
            @(posedge clk); #1;
            checks++;
            if (bus.cfg_valid !== 1'b1 || got_frame() !== fr) begin
                errors++;
                $display("FAIL stall_frame%0d: got valid=%b fields=%h want 1/%h", i,
                         bus.cfg_valid, got_frame(), fr);
            end
            @(posedge clk); #1;
            core_ack(2);
        end
        checks++;
        if (bus.frame_cnt !== 16'd3) begin
            errors++; $display("FAIL stall_cnt: got %0d want 3", bus.frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [143:0] fa, fb, fc;
        logic [159:0] pad;
        fa = mk_frame(48'h0F0F_0F0F_0F0F, 40'hF0_F0F0_F0F0, 32'h1234_5678, 24'h765432);
        fb = mk_frame(48'hDDDD_DDDD_DDDD, 40'hEE_EEEE_EEEE, 32'h9999_9999, 24'h888888);
        fc = mk_frame(48'h2468_ACE0_1357, 40'h9B_DF02_4681, 32'hCAFE_BABE, 24'h13579B);
        do_reset();
        send_frame(fa, 1'b0, -1);
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cfg_valid !== 1'b0 || bus.frame_cnt !== 16'd0 || got_frame() !== 144'h0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b cnt=%0d fields=%h want 0/0/0",
                     bus.cfg_valid, bus.frame_cnt, got_frame());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pad = {16'h0, fb};
        for (int k = 0; k < 3; k++) send_beat(pad[k*32 +: 32], ^pad[k*32 +: 32]);
        #2;
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.cfg_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_frame: got ready=%b valid=%b want 0/0", bus.in_ready,
                     bus.cfg_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(fc, 1'b0, -1);
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== fc || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_new_frame: got valid=%b fields=%h cnt=%0d want 1/%h/1",
                     bus.cfg_valid, got_frame(), bus.frame_cnt, fc);
        end
        @(posedge clk); #1;
        core_ack(1);
    endtask

    task automatic test_parity();
        logic [143:0] f1, f2;
        bit           seen;
        f1 = mk_frame(48'h7777_6666_5555, 40'h44_3333_2222, 32'h1111_0000, 24'hFFEEDD);
        f2 = mk_frame(48'h3141_5926_5358, 40'h97_9323_8462, 32'h6433_8327, 24'h950288);
        do_reset();
        send_frame(f1, 1'b0, 2);
`ifdef CFG_DISPATCHER_PARITY_EN
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.cfg_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || bus.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL parity_drop: got valid seen=%b cnt=%0d want 0/0", seen,
                     bus.frame_cnt);
        end
        checks++;
        if (bus.err_parity !== 1'b1) begin
            errors++; $display("FAIL parity_err_set: got %b want 1", bus.err_parity);
        end
        send_frame(f2, 1'b0, -1);
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== f2 || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL parity_clean_issue: got valid=%b fields=%h cnt=%0d want 1/%h/1",
                     bus.cfg_valid, got_frame(), bus.frame_cnt, f2);
        end
        checks++;
        if (bus.err_parity !== 1'b1) begin
            errors++; $display("FAIL parity_err_sticky: got %b want 1", bus.err_parity);
        end
        @(posedge clk); #1;
        core_ack(1);
`else
        seen = 1'b0;
        @(posedge clk); #1;
        if (bus.cfg_valid === 1'b1) seen = 1'b1;
        checks++;
        if (seen !== 1'b1 || got_frame() !== f1 || bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL noparity_issue: got valid=%b fields=%h cnt=%0d want 1/%h/1",
                     seen, got_frame(), bus.frame_cnt, f1);
        end
        checks++;
        if (bus.err_parity !== 1'b0) begin
            errors++; $display("FAIL noparity_err: got %b want 0", bus.err_parity);
        end
        @(posedge clk); #1;
        core_ack(1);
        send_frame(f2, 1'b0, 0);
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_valid !== 1'b1 || got_frame() !== f2 || bus.err_parity !== 1'b0) begin
            errors++;
            $display("FAIL noparity_second: got valid=%b fields=%h err=%b want 1/%h/0",
                     bus.cfg_valid, got_frame(), bus.err_parity, f2);
        end
        @(posedge clk); #1;
        core_ack(1);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_frame();
        test_busy_hold();
        test_back_to_back();
        test_stalled_stream();
        test_reset_mid();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cfg_dispatcher.md
Name: cfg_dispatcher

Overview:
- Upstream stage of the PE-array accelerator core's configuration port (cfg_valid / cfg_busy / cfg_*_data).
- Deserializes a narrow instruction-word stream into one full configuration frame: the data, wicp, tmpc and post fields.
- Issues each frame to the core with a cfg_valid pulse, and only when the core is not busy.
- Holds one assembled frame while the core works, so the next frame's beats are collected during the current run.

Parameters:
- IWIDTH, 32, instruction stream word width.
- DATA_CWIDTH, 48, width of cfg_data_data.
- WICP_CWIDTH, 40, width of cfg_wicp_data.
- TMPC_CWIDTH, 32, width of cfg_tmpc_data.
- POST_CWIDTH, 24, width of cfg_post_data.
- Derived, not overridable: CWIDTH = sum of the four field widths = 144. BEATS = ceil(CWIDTH/IWIDTH) = 5.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: instruction word valid.
- in_ready, output, 1: dispatcher accepts a word.
- in_data, input, IWIDTH: instruction word.
- in_parity, input, 1: even parity of in_data; used only with the optional feature.
- cfg_valid, output, 1: one-cycle frame issue pulse to the core.
- cfg_busy, input, 1: core busy.
- cfg_data_data, output, DATA_CWIDTH: data field.
- cfg_wicp_data, output, WICP_CWIDTH: wicp field.
- cfg_tmpc_data, output, TMPC_CWIDTH: tmpc field.
- cfg_post_data, output, POST_CWIDTH: post field.
- frame_cnt, output, 16: number of frames issued; wraps.
- err_parity, output, 1: sticky parity error.

Behaviour:
- Decided: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 for the first cycle after reset release, then follows the rules below. cfg_valid=0, all cfg_*_data=0, frame_cnt=0, err_parity=0. Beat counter=0, both frame buffers empty, FSM in IDLE.
- Frame packing: frame = {post, tmpc, wicp, data}, LSB-first. Beat k carries frame bits [k*IWIDTH +: IWIDTH]. Bits above CWIDTH in the last beat are ignored.
- Assembly buffer (ABUF):
  - A word transfers when in_valid && in_ready.
  - in_ready=1 whenever ABUF is not full. ABUF is full after BEATS beats, until it moves to the issue buffer.
  - The beat counter runs 0..BEATS-1 and wraps to 0 on the last beat.
  - in_valid may drop mid-frame; partial beats are retained indefinitely.
- Issue buffer (IBUF) drives cfg_*_data. The outputs are registered and stable from cfg_valid until the next issue.
- ABUF to IBUF move: when ABUF is full and IBUF is empty, the move takes one cycle. ABUF is freed the same cycle, so in_ready can reassert on the next cycle.
- FSM:
  - IDLE: if IBUF is full and cfg_busy=0, go to ISSUE. If cfg_busy=1, stay.
  - ISSUE: cfg_valid=1 for exactly this cycle; frame_cnt++ (wraps 0xFFFF to 0); go to WAIT_ACK.
  - WAIT_ACK: wait for cfg_busy=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: wait for cfg_busy=0, then mark IBUF empty and go to IDLE.
- IBUF refill: may happen in the same cycle IBUF empties. The next cfg_valid then comes no earlier than 2 cycles after cfg_busy falls.
- Latency: last beat accepted at cycle T (IBUF empty, core idle) gives cfg_valid at T+2.
- Back-to-back frames: the 5 beats of frame N+1 are accepted while frame N is in WAIT_ACK / WAIT_DONE. Afterwards in_ready stays 0 until IBUF frees.
- Simultaneous events: a last beat and a same-cycle IBUF empty are both honoured. The move happens the next cycle.
- cfg_busy=1 in IDLE with a frame ready: hold, no issue.
- Reset mid-operation: all state is discarded, including partial frames and a pending issue. cfg_valid deasserts immediately (asynchronously).

Optional Feature:
- Macro: CFG_DISPATCHER_PARITY_EN.
- Defined:
  - Each accepted beat is checked: ^in_data must equal in_parity.
  - On a mismatch, err_parity sets (sticky until reset).
  - The whole current frame is dropped: the beat counter runs to the frame end and ABUF is cleared instead of moved. The frame is never issued.
- Undefined: in_parity is ignored, err_parity is tied to 0, no check logic exists.

Test Plan:
- Single frame: 5 beats, data field 48'h0123_4567_89AB, post 24'hABCDEF, cfg_busy=0 → cfg_valid pulse 2 cycles after the last beat. Fields match exactly. frame_cnt=1.
- Busy hold: cfg_busy=1 throughout while a frame is assembled → no cfg_valid. Drop busy → cfg_valid 1 cycle later. Core raises busy 3 cycles, then drops → FSM back to IDLE.
- Pipelined frames: frames A and B streamed continuously; core busy 20 cycles per frame → B is fully accepted during A's run, in_ready=0 afterwards. B issues 2 cycles after busy falls. frame_cnt=2.
- Stalled stream: in_valid toggled randomly mid-frame, 3 frames → correct reassembly, no beat loss or duplication.
- Reset mid-frame: rst_n low after beat 3 → outputs reset. A new 5-beat frame after release issues correctly. frame_cnt=1.
- Parity (macro defined): beat 2 of frame 1 has a flipped parity bit → frame 1 not issued, err_parity=1. Frame 2 (clean) issues. frame_cnt=1.
